// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcode mnemonics, FSM states
// and the DECODE routing function.
package Definitions;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    AOL = 4'd1,
    CLR = 4'd2,
    BNE = 4'd3,
    LDR = 4'd4,
    STR = 4'd5,
    CMP = 4'd6,
    XOR = 4'd7,
    LSL = 4'd8,
    LSR = 4'd9,
    MOV = 4'd10,
    HLT = 4'd15
  } op_mne;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT,
    FAULT
  } ctrl_state_e;

  // Encodings 11-14 are reserved and land in FAULT.
  function automatic ctrl_state_e decode_route(input logic [3:0] op);
    case (op)
      ADD, AOL, CLR, XOR, LSL, LSR, MOV, CMP, BNE: return EXEC;
      LDR, STR:                                    return MEM;
      HLT:                                         return HALT;
      default:                                     return FAULT;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_sequencer_timer.sv
// Data-memory wait timer: armed by start, reports ack (done) or expiry of the
// MEM_TIMEOUT-cycle window (timeout); idle otherwise so stray acks are ignored.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic done,
  output logic timeout
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          armed;

  // cnt holds the 1-based index of the current MEM cycle; an ack in the last
  // allowed cycle wins over the timeout.
  assign done    = armed & ack;
  assign timeout = armed & ~ack & (cnt == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      armed <= 1'b1;
      cnt   <= CW'(1);
    end else if (done || timeout) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (armed) begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback FSM
// with sticky HALT/FAULT and a retired-instruction counter.
module ctrl_sequencer #(
  parameter int unsigned INSTR_W     = 9,
  parameter int unsigned OP_W        = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               run_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               alu_zero_i,
  input  logic               mem_ack_i,
  output logic               ir_load_o,
  output logic [OP_W-1:0]    alu_op_o,
  output logic               reg_we_o,
  output logic               mem_rd_o,
  output logic               mem_wr_o,
  output logic               pc_en_o,
  output logic               branch_o,
  output logic               halted_o,
  output logic               fault_o,
  output logic [CNT_W-1:0]   retired_o
);

  import Definitions::*;

  ctrl_state_e     state;
  ctrl_state_e     state_nx;
  logic [OP_W-1:0] op_q;
  logic            flag_z;
  op_mne           op;
  ctrl_state_e     route;
  logic            timer_start;
  logic            mem_done;
  logic            mem_timeout;
  logic            unused_operand;

  assign unused_operand = ^instr_i[INSTR_W-OP_W-1:0];

  assign op          = op_mne'(alu_op_o[3:0]);
  assign route       = decode_route(op_q[3:0]);
  assign timer_start = (state == DECODE) && (route == MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (Clk),
    .rst    (Reset),
    .start  (timer_start),
    .ack    (mem_ack_i),
    .done   (mem_done),
    .timeout(mem_timeout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (run_i) state_nx = DECODE;
      DECODE:  state_nx = route;
      EXEC:    state_nx = (op == CMP || op == BNE) ? FETCH : WB;
      MEM: begin
        if (mem_done)         state_nx = (op == LDR) ? WB : FETCH;
        else if (mem_timeout) state_nx = FAULT;
      end
      WB:      state_nx = FETCH;
      HALT:    state_nx = HALT;
      FAULT:   state_nx = FAULT;
      default: state_nx = FAULT;
    endcase
  end

  // STR retires in its ack cycle, so pc_en_o depends on the live ack there.
  assign ir_load_o = (state == FETCH) && run_i;
  assign reg_we_o  = (state == WB);
  assign mem_rd_o  = (state == MEM) && (op == LDR);
  assign mem_wr_o  = (state == MEM) && (op == STR);
  assign pc_en_o   = (state == WB)
                   || ((state == EXEC) && (op == CMP || op == BNE))
                   || ((state == MEM) && (op == STR) && mem_done);
  assign branch_o  = (state == EXEC) && (op == BNE) && !flag_z;
  assign halted_o  = (state == HALT);
  assign fault_o   = (state == FAULT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= FETCH;
      op_q      <= '0;
      alu_op_o  <= '0;
      flag_z    <= 1'b0;
      retired_o <= '0;
    end else begin
      state <= state_nx;
      if (ir_load_o) op_q <= instr_i[INSTR_W-1 -: OP_W];
      if (state == DECODE) alu_op_o <= op_q;
      if (state == EXEC && op == CMP) flag_z <= alu_zero_i;
      if (pc_en_o) retired_o <= retired_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: stimulus pushes one expected record per
// retiring instruction; a monitor pops and checks on every pc_en_o.
module tb_ctrl_sequencer;
  import Definitions::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       run_i;
  logic [8:0] instr_i;
  logic       alu_zero_i;
  logic       mem_ack_i;
  logic       ir_load_o;
  logic [3:0] alu_op_o;
  logic       reg_we_o;
  logic       mem_rd_o;
  logic       mem_wr_o;
  logic       pc_en_o;
  logic       branch_o;
  logic       halted_o;
  logic       fault_o;
  logic [15:0] retired_o;

  ctrl_sequencer #(
    .INSTR_W(9),
    .OP_W(4),
    .MEM_TIMEOUT(15),
    .CNT_W(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .run_i(run_i), .instr_i(instr_i),
    .alu_zero_i(alu_zero_i), .mem_ack_i(mem_ack_i), .ir_load_o(ir_load_o),
    .alu_op_o(alu_op_o), .reg_we_o(reg_we_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .pc_en_o(pc_en_o), .branch_o(branch_o),
    .halted_o(halted_o), .fault_o(fault_o), .retired_o(retired_o)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  typedef struct {
    int         cyc;
    logic       we;
    logic       br;
    logic       wr;
    logic [3:0] op;
    logic [15:0] ret;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] ret_m = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  always @(negedge Clk) begin : mon
    exp_t e;
    #2;
    if (pc_en_o === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("pc_en_unexpected", {31'b0, pc_en_o}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("pc_en_cycle", cyc, e.cyc);
        chk("reg_we", {31'b0, reg_we_o}, {31'b0, e.we});
        chk("branch", {31'b0, branch_o}, {31'b0, e.br});
        chk("mem_wr", {31'b0, mem_wr_o}, {31'b0, e.wr});
        chk("alu_op", {28'b0, alu_op_o}, {28'b0, e.op});
        chk("retired_pre", {16'b0, retired_o}, {16'b0, e.ret});
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called at a falling edge: presents the instruction for its FETCH cycle.
  task automatic issue(input logic [3:0] op, input int lat, input logic we,
                       input logic br, input logic wr, input bit has_pc);
    exp_t e;
    run_i   = 1'b1;
    instr_i = {op, 5'h0b};
    if (has_pc) begin
      e.cyc = cyc + lat - 1;
      e.we  = we;
      e.br  = br;
      e.wr  = wr;
      e.op  = op;
      e.ret = ret_m;
      sbq.push_back(e);
      ret_m++;
    end
    #2 chk("ir_load", {31'b0, ir_load_o}, 32'd1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    run_i = 1'b0;
    mem_ack_i = 1'b0;
    nclk(2);
    Reset = 1'b0;
    ret_m = '0;
    #2;
    chk("rst_fault", {31'b0, fault_o}, 32'd0);
    chk("rst_halted", {31'b0, halted_o}, 32'd0);
    chk("rst_retired", {16'b0, retired_o}, 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rd;
    int n_wr;
    Reset = 1'b1;
    run_i = 1'b0;
    instr_i = '0;
    alu_zero_i = 1'b0;
    mem_ack_i = 1'b0;

    // Reset state
    nclk(3);
    #2;
    chk("reset_state", {29'b0, dut.state}, {29'b0, FETCH});
    chk("reset_ir_load", {31'b0, ir_load_o}, 32'd0);
    chk("reset_pc_en", {31'b0, pc_en_o}, 32'd0);
    chk("reset_mem_rd", {31'b0, mem_rd_o}, 32'd0);
    chk("reset_alu_op", {28'b0, alu_op_o}, 32'd0);
    chk("reset_retired", {16'b0, retired_o}, 32'd0);
    chk("reset_fault", {31'b0, fault_o}, 32'd0);
    nclk(1);
    Reset = 1'b0;
    nclk(1);

    // ADD, XOR, MOV back-to-back
    issue(ADD, 4, 1'b1, 1'b0, 1'b0, 1'b1); nclk(4);
    issue(XOR, 4, 1'b1, 1'b0, 1'b0, 1'b1); nclk(4);
    issue(MOV, 4, 1'b1, 1'b0, 1'b0, 1'b1); nclk(4);
    run_i = 1'b0;
    #2 chk("retired_after_3", {16'b0, retired_o}, 32'd3);

    // CMP (zero=0) / BNE -> taken; CMP (zero=1) / BNE -> not taken
    nclk(1);
    alu_zero_i = 1'b0;
    issue(CMP, 3, 1'b0, 1'b0, 1'b0, 1'b1); nclk(3);
    alu_zero_i = 1'b1;
    issue(BNE, 3, 1'b0, 1'b1, 1'b0, 1'b1); nclk(3);
    #2 chk("flag_z_clear", {31'b0, dut.flag_z}, 32'd0);
    alu_zero_i = 1'b1;
    issue(CMP, 3, 1'b0, 1'b0, 1'b0, 1'b1); nclk(3);
    alu_zero_i = 1'b0;
    issue(BNE, 3, 1'b0, 1'b0, 1'b0, 1'b1); nclk(3);
    #2 chk("flag_z_set", {31'b0, dut.flag_z}, 32'd1);
    issue(ADD, 4, 1'b1, 1'b0, 1'b0, 1'b1); nclk(4);
    run_i = 1'b0;
    #2 chk("flag_z_kept", {31'b0, dut.flag_z}, 32'd1);

    // LDR, ack after 3 wait cycles; ack during DECODE must be ignored
    nclk(1);
    issue(LDR, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    n_rd = 0;
    for (int k = 1; k <= 7; k++) begin
      nclk(1);
      run_i = 1'b0;
      mem_ack_i = (k == 1 || k == 5);
      #2;
      if (mem_rd_o) n_rd++;
      if (k == 6) chk("ldr_wb_we", {31'b0, reg_we_o}, 32'd1);
    end
    mem_ack_i = 1'b0;
    chk("ldr_rd_cycles", n_rd, 4);

    // Minimum latencies: ack in first MEM cycle
    nclk(1);
    issue(LDR, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    nclk(1); run_i = 1'b0;
    nclk(1); mem_ack_i = 1'b1;
    nclk(1); mem_ack_i = 1'b0;
    nclk(1);
    issue(STR, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    nclk(1); run_i = 1'b0;
    nclk(1); mem_ack_i = 1'b1;
    nclk(1); mem_ack_i = 1'b0;

    // STR with ack in the 15th MEM cycle is still accepted
    nclk(1);
    issue(STR, 17, 1'b0, 1'b0, 1'b1, 1'b1);
    nclk(1); run_i = 1'b0;
    nclk(14);
    nclk(1); mem_ack_i = 1'b1;
    #2 chk("str_ack15_no_fault", {31'b0, fault_o}, 32'd0);
    nclk(1); mem_ack_i = 1'b0;
    #2 chk("str_ack15_fetch", {29'b0, dut.state}, {29'b0, FETCH});
    chk("retired_before_fault", {16'b0, retired_o}, {16'b0, ret_m});

    // STR with no ack: FAULT after 15 MEM cycles, sticky until reset
    nclk(1);
    issue(STR, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_wr = 0;
    for (int k = 1; k <= 17; k++) begin
      nclk(1);
      run_i = 1'b0;
      #2;
      if (mem_wr_o) n_wr++;
      if (k == 16) chk("str_to_fault_early", {31'b0, fault_o}, 32'd0);
      if (k == 17) chk("str_timeout_fault", {31'b0, fault_o}, 32'd1);
    end
    chk("str_wr_cycles", n_wr, 15);
    for (int k = 0; k < 4; k++) begin
      nclk(1);
      run_i = 1'b1;
      instr_i = {4'(ADD), 5'h00};
      mem_ack_i = 1'b1;
      #2;
      chk("fault_sticky", {31'b0, fault_o}, 32'd1);
      chk("fault_no_ir_load", {31'b0, ir_load_o}, 32'd0);
    end
    nclk(1);
    do_reset();

    // Reserved opcode 12 -> FAULT the cycle after DECODE
    nclk(1);
    issue(4'd12, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    nclk(1); run_i = 1'b0;
    #2 chk("op12_decode_no_fault", {31'b0, fault_o}, 32'd0);
    nclk(1);
    #2 chk("op12_fault", {31'b0, fault_o}, 32'd1);
    nclk(1);
    do_reset();

    // HLT: halted, retired_o unchanged
    nclk(1);
    issue(ADD, 4, 1'b1, 1'b0, 1'b0, 1'b1); nclk(4);
    issue(HLT, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    nclk(1); run_i = 1'b0;
    nclk(1);
    #2;
    chk("hlt_halted", {31'b0, halted_o}, 32'd1);
    chk("hlt_retired", {16'b0, retired_o}, 32'd1);
    nclk(1); run_i = 1'b1;
    nclk(2);
    #2;
    chk("hlt_sticky", {31'b0, halted_o}, 32'd1);
    chk("hlt_retired_kept", {16'b0, retired_o}, 32'd1);
    nclk(1);
    do_reset();

    // Reset during LDR MEM wait abandons the request
    nclk(1);
    alu_zero_i = 1'b1;
    issue(CMP, 3, 1'b0, 1'b0, 1'b0, 1'b1); nclk(3);
    alu_zero_i = 1'b0;
    issue(ADD, 4, 1'b1, 1'b0, 1'b0, 1'b1); nclk(4);
    issue(LDR, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    nclk(1); run_i = 1'b0;
    nclk(2);
    #2 chk("ldr_wait_rd", {31'b0, mem_rd_o}, 32'd1);
    Reset = 1'b1;
    nclk(1);
    Reset = 1'b0;
    ret_m = '0;
    #2;
    chk("rst_mid_mem_rd", {31'b0, mem_rd_o}, 32'd0);
    chk("rst_mid_mem_state", {29'b0, dut.state}, {29'b0, FETCH});
    chk("rst_mid_mem_retired", {16'b0, retired_o}, 32'd0);
    chk("rst_mid_mem_flag_z", {31'b0, dut.flag_z}, 32'd0);
    chk("rst_mid_mem_alu_op", {28'b0, alu_op_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      nclk(1);
      mem_ack_i = 1'b1;
      #2 chk("no_retry_rd", {31'b0, mem_rd_o}, 32'd0);
    end
    mem_ack_i = 1'b0;
    nclk(2);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The block SHALL take parameter INSTR_W, default 9, giving the instruction word width.
REQ-002 The block SHALL take parameter OP_W, default 4, giving the opcode field width, taken from instr bits [INSTR_W-1 -: OP_W].
REQ-003 The block SHALL take parameter MEM_TIMEOUT, default 15, giving the maximum cycles to wait for mem_ack before faulting.
REQ-004 The block SHALL take parameter CNT_W, default 16, giving the retired-instruction counter width.
REQ-005 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 run_i  input  1  permits instruction fetch when high.
REQ-008 instr_i  input  INSTR_W  instruction word from instruction memory, valid in the FETCH cycle.
REQ-009 alu_zero_i  input  1  ALU zero result, sampled in EXEC of CMP.
REQ-010 mem_ack_i  input  1  data memory completion strobe.
REQ-011 ir_load_o  output  1  instruction-register load strobe.
REQ-012 alu_op_o  output  OP_W  latched opcode, driven to the ALU.
REQ-013 reg_we_o  output  1  register-file write enable.
REQ-014 mem_rd_o / mem_wr_o  output  1 each  data memory read/write request, held until ack.
REQ-015 pc_en_o  output  1  PC advance strobe, exactly one cycle per retired instruction.
REQ-016 branch_o  output  1  PC loads branch target instead of incrementing; valid only with pc_en_o.
REQ-017 halted_o / fault_o  output  1 each  sticky HALT and FAULT status.
REQ-018 retired_o  output  CNT_W  count of retired instructions.

Function
REQ-019 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT and FAULT.
REQ-020 In FETCH with run_i=1, the block SHALL assert ir_load_o, latch instr_i and go to DECODE; with run_i=0 it SHALL stay in FETCH with all strobes low.
REQ-021 DECODE SHALL take one cycle.
REQ-022 From DECODE, the block SHALL route to EXEC for ADD, AOL, CLR, XOR, LSL, LSR, MOV, CMP and BNE; to MEM for LDR and STR; to HALT for HLT; and to FAULT for any unlisted encoding.
REQ-023 ADD/AOL/CLR/XOR/LSL/LSR/MOV SHALL follow FETCH-DECODE-EXEC-WB, taking 4 cycles, with reg_we_o and pc_en_o asserted in WB.
REQ-024 CMP SHALL take 3 cycles; in EXEC it SHALL load internal flag_z from alu_zero_i and assert pc_en_o, then go to FETCH.
REQ-025 BNE SHALL take 3 cycles; in EXEC it SHALL assert pc_en_o, with branch_o = ~flag_z.
REQ-026 LDR SHALL hold mem_rd_o in MEM until mem_ack_i, then go to WB, where reg_we_o and pc_en_o are asserted.
REQ-027 STR SHALL hold mem_wr_o in MEM until mem_ack_i, asserting pc_en_o in the ack cycle, then go to FETCH.
REQ-028 mem_ack_i SHALL be ignored outside MEM.
REQ-029 An ack in the first MEM cycle SHALL be accepted, giving minimum latencies of LDR 4 cycles and STR 3 cycles.
REQ-030 A MEM wait counter SHALL enter FAULT if MEM_TIMEOUT cycles elapse without ack; an ack in the MEM_TIMEOUT-th cycle SHALL still be accepted.
REQ-031 HALT and FAULT SHALL be terminal until Reset, with all strobes low and halted_o or fault_o high respectively.
REQ-032 HLT SHALL NOT increment retired_o.
REQ-033 retired_o SHALL increment on every pc_en_o and wrap from all-ones to 0.
REQ-034 alu_op_o SHALL hold the latched opcode from DECODE until the next ir_load_o.
REQ-035 flag_z SHALL be modified only by CMP.

Reset
REQ-036 Reset SHALL take priority over all inputs, including mid-MEM, and return the FSM to FETCH.
REQ-037 Reset SHALL clear flag_z, the MEM wait counter, retired_o, alu_op_o, halted_o and fault_o, and drive all strobes low in the cycle after Reset is sampled.
REQ-038 A memory request cut off by Reset SHALL be abandoned, not retried.

Structure
REQ-039 The shared package Definitions SHALL define op_mne as a logic[3:0] enum: ADD=0, AOL=1, CLR=2, BNE=3, LDR=4, STR=5, CMP=6, XOR=7, LSL=8, LSR=9, MOV=10, HLT=15, with 11-14 reserved.
REQ-040 The package SHALL also define the state enum ctrl_state_e.
REQ-041 The MEM wait/timeout counter SHALL be one sub-module, mem_wait_timer, with inputs start, ack and outputs done, timeout.

Verification
REQ-042 The bench SHALL apply ADD, XOR, MOV back-to-back with run_i=1 and check pc_en_o at cycles 4, 8 and 12, reg_we_o in each WB, and retired_o=3.
REQ-043 The bench SHALL apply CMP with alu_zero_i=0 then BNE, check branch_o=1 with pc_en_o at cycle 6, then repeat with alu_zero_i=1 and check branch_o=0.
REQ-044 The bench SHALL apply LDR with mem_ack_i after 3 wait cycles and check mem_rd_o high for exactly 4 cycles, then WB with reg_we_o=1.
REQ-045 The bench SHALL apply STR with no ack and check fault_o=1 after 15 MEM cycles, then check the FSM stays in FAULT until Reset.
REQ-046 The bench SHALL apply opcode 12 and check fault_o=1 the cycle after DECODE, then apply HLT and check halted_o=1 with retired_o unchanged.
REQ-047 The bench SHALL assert Reset during an LDR MEM wait and check, next cycle, mem_rd_o=0, state FETCH, retired_o=0 and flag_z=0.
